// File: rtl/hazard_pkg.sv
// Shared types and elaboration helpers for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic {IDLE = 1'b0, LD_STALL = 1'b1} hz_state_e;

   // Bits needed to hold max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      int w = 1;
      while ((1 << w) <= max_val) w++;
      return w;
   endfunction

   function automatic bit lat_ok(input int lat);
      return lat >= 1;
   endfunction

endpackage

// File: rtl/hz_down_counter.sv
// Loadable down-counter that stops at zero; clear wins over load.
module hz_down_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)               cnt_d = '0;
      else if (load_i)         cnt_d = load_val_i;
      else if (cnt_q != '0)    cnt_d = cnt_q - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / MDU-busy stall and taken-branch flush control for the 5-stage pipeline,
// with a saturating stalled-cycle counter.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int MDU_LAT  = 4,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  IFID_rs,
   input  logic [REG_W-1:0]  IFID_rt,
   input  logic [REG_W-1:0]  IDEX_rt,
   input  logic              memread,
   input  logic              mdu_start,
   input  logic              IFID_mdu_use,
   input  logic              branch_taken,
   output logic              IFIDWrite,
   output logic              PCWrite,
   output logic              HazardMux,
   output logic              IFIDFlush,
   output logic              stall_active,
   output logic [PERF_W-1:0] stall_count
);

   localparam int LW = cnt_w(LOAD_LAT - 1);
   localparam int MW = cnt_w(MDU_LAT - 1);

   if (!lat_ok(LOAD_LAT) || !lat_ok(MDU_LAT)) begin : g_bad_lat
      $error("hazard_stall_ctrl: LOAD_LAT and MDU_LAT must be >= 1");
   end

   hz_state_e         state_q;
   logic [LW-1:0]     ld_cnt;
   logic [MW-1:0]     mdu_cnt;
   logic              ld_zero, mdu_zero;
   logic              ld_hz, mdu_hz, stall, ld_load;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

   assign ld_hz   = memread && (IDEX_rt != '0) && ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
   assign mdu_hz  = (!mdu_zero || mdu_start) && IFID_mdu_use;
   assign stall   = (ld_hz && state_q == IDLE) || (state_q == LD_STALL) || mdu_hz;
   // The first stalled cycle is spent in IDLE; the FSM only covers the extra LOAD_LAT-1.
   assign ld_load = (LOAD_LAT > 1) && !branch_taken && (state_q == IDLE) && ld_hz;

   hz_down_counter #(.WIDTH(LW)) u_ld_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (branch_taken),
      .load_i     (ld_load),
      .load_val_i (LW'(LOAD_LAT - 1)),
      .cnt_o      (ld_cnt),
      .zero_o     (ld_zero)
   );

   // A taken branch leaves the MDU alone: its op is older than the branch.
   hz_down_counter #(.WIDTH(MW)) u_mdu_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (1'b0),
      .load_i     (mdu_start),
      .load_val_i (MW'(MDU_LAT - 1)),
      .cnt_o      (mdu_cnt),
      .zero_o     (mdu_zero)
   );

   logic unused_cnt_bits;
   assign unused_cnt_bits = ^{ld_zero, mdu_cnt};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else if (branch_taken) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:     if (ld_load) state_q <= LD_STALL;
            LD_STALL: if (ld_cnt == LW'(1)) state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      IFIDWrite    = 1'b1;
      PCWrite      = 1'b1;
      HazardMux    = 1'b0;
      IFIDFlush    = 1'b0;
      stall_active = 1'b0;
      if (reset) begin
         IFIDWrite = 1'b1;
      end else if (branch_taken) begin
         HazardMux = 1'b1;
         IFIDFlush = 1'b1;
      end else if (stall) begin
         IFIDWrite    = 1'b0;
         PCWrite      = 1'b0;
         HazardMux    = 1'b1;
         stall_active = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_active && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed vector bench: two controllers (LOAD_LAT=3/PERF_W=16 and LOAD_LAT=1/PERF_W=2) share stimulus.
module tb_hazard_stall_ctrl;

   localparam int MN = 0, MS = 1, MF = 2;

   typedef struct {
      logic       rst;
      logic [4:0] rs, rt, xrt;
      logic       mr, ms, mu, br;
      int         ma, mb;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] IFID_rs, IFID_rt, IDEX_rt;
   logic memread, mdu_start, IFID_mdu_use, branch_taken;
   logic a_ifidw, a_pcw, a_hm, a_fl, a_sa;
   logic b_ifidw, b_pcw, b_hm, b_fl, b_sa;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   logic [15:0] cnt_a_exp;
   logic [1:0]  cnt_b_exp;
   int total = 0;
   int bad = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .MDU_LAT(4), .PERF_W(16)) u_a (
      .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IDEX_rt(IDEX_rt),
      .memread(memread), .mdu_start(mdu_start), .IFID_mdu_use(IFID_mdu_use),
      .branch_taken(branch_taken), .IFIDWrite(a_ifidw), .PCWrite(a_pcw), .HazardMux(a_hm),
      .IFIDFlush(a_fl), .stall_active(a_sa), .stall_count(a_cnt));

   hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .MDU_LAT(4), .PERF_W(2)) u_b (
      .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IDEX_rt(IDEX_rt),
      .memread(memread), .mdu_start(mdu_start), .IFID_mdu_use(IFID_mdu_use),
      .branch_taken(branch_taken), .IFIDWrite(b_ifidw), .PCWrite(b_pcw), .HazardMux(b_hm),
      .IFIDFlush(b_fl), .stall_active(b_sa), .stall_count(b_cnt));

   // {IFIDWrite, PCWrite, HazardMux, IFIDFlush, stall_active}
   function automatic logic [4:0] exp_out(input int mode);
      case (mode)
         MS:      return 5'b00101;
         MF:      return 5'b11110;
         default: return 5'b11000;
      endcase
   endfunction

   function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] xrt, input logic mr, input logic ms,
                               input logic mu, input logic br, input int ma, input int mb);
      vec_t v;
      v.rst = rst; v.rs = rs; v.rt = rt; v.xrt = xrt;
      v.mr = mr; v.ms = ms; v.mu = mu; v.br = br; v.ma = ma; v.mb = mb;
      return v;
   endfunction

   task automatic step(input vec_t v, input string tag);
      logic [4:0] got_a, got_b;
      @(negedge clk);
      reset = v.rst; IFID_rs = v.rs; IFID_rt = v.rt; IDEX_rt = v.xrt;
      memread = v.mr; mdu_start = v.ms; IFID_mdu_use = v.mu; branch_taken = v.br;
      #2;
      got_a = {a_ifidw, a_pcw, a_hm, a_fl, a_sa};
      got_b = {b_ifidw, b_pcw, b_hm, b_fl, b_sa};
      total++;
      if (got_a !== exp_out(v.ma)) begin
         bad++; $display("FAIL %s outA got=%b want=%b", tag, got_a, exp_out(v.ma));
      end
      total++;
      if (a_cnt !== cnt_a_exp) begin
         bad++; $display("FAIL %s cntA got=%0d want=%0d", tag, a_cnt, cnt_a_exp);
      end
      total++;
      if (got_b !== exp_out(v.mb)) begin
         bad++; $display("FAIL %s outB got=%b want=%b", tag, got_b, exp_out(v.mb));
      end
      total++;
      if (b_cnt !== cnt_b_exp) begin
         bad++; $display("FAIL %s cntB got=%0d want=%0d", tag, b_cnt, cnt_b_exp);
      end
      if (v.rst) begin
         cnt_a_exp = '0;
         cnt_b_exp = '0;
      end else begin
         if (v.ma == MS) cnt_a_exp = cnt_a_exp + 16'd1;
         if (v.mb == MS && cnt_b_exp != 2'd3) cnt_b_exp = cnt_b_exp + 2'd1;
      end
   endtask

   initial begin
      reset = 1'b1; IFID_rs = '0; IFID_rt = '0; IDEX_rt = '0;
      memread = 1'b0; mdu_start = 1'b0; IFID_mdu_use = 1'b0; branch_taken = 1'b0;
      cnt_a_exp = '0; cnt_b_exp = '0;
      repeat (2) @(posedge clk);

      //              rst rs    rt    xrt   mr ms mu br  A   B
      tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, MN, MN));  // reset state
      tbl.push_back(mk(0, 5'd8, 5'd9, 5'd8, 0, 0, 0, 0, MN, MN));  // match but no load
      tbl.push_back(mk(0, 5'd8, 5'd9, 5'd8, 1, 0, 0, 0, MS, MS));  // load-use on rs
      tbl.push_back(mk(0, 5'd8, 5'd9, 5'd8, 0, 0, 0, 0, MS, MN));
      tbl.push_back(mk(0, 5'd8, 5'd9, 5'd8, 0, 0, 0, 0, MS, MN));
      tbl.push_back(mk(0, 5'd8, 5'd9, 5'd8, 0, 0, 0, 0, MN, MN));  // A back in IDLE
      tbl.push_back(mk(0, 5'd0, 5'd9, 5'd0, 1, 0, 0, 0, MN, MN));  // $0 never hazards
      tbl.push_back(mk(0, 5'd3, 5'd5, 5'd5, 1, 0, 0, 0, MS, MS));  // load-use on rt
      tbl.push_back(mk(0, 5'd3, 5'd5, 5'd5, 0, 0, 0, 1, MF, MF));  // branch in 2nd stall cycle
      tbl.push_back(mk(0, 5'd3, 5'd5, 5'd5, 0, 0, 0, 0, MN, MN));  // no 3rd stall
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, MS, MS));  // MDU start + use
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MN, MN));  // released on 5th cycle
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, MN, MN));  // busy, no consumer
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 1, MF, MF));  // branch beats MDU stall
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS));  // MDU count survived branch
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MN, MN));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, MN, MN));  // MDU busy
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 1, 0, 1, 0, MS, MS));  // load + MDU together
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 0, 0, 1, 0, MS, MS));
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 0, 0, 1, 0, MN, MN));
      tbl.push_back(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, MN, MN));  // MDU busy
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 1, 0, 0, 0, MS, MS));  // A enters LD_STALL
      tbl.push_back(mk(1, 5'd8, 5'd2, 5'd8, 0, 0, 1, 0, MN, MN));  // reset mid-stall
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 0, 0, 1, 0, MN, MN));  // no residue
      tbl.push_back(mk(0, 5'd8, 5'd2, 5'd8, 0, 0, 0, 0, MN, MN));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

      // Newest MDU op wins: restart while busy extends the stall.
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, MN, MN), "rl0");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, MN, MN), "rl1");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, MS, MS), "rl2");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS), "rl3");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS), "rl4");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MS, MS), "rl5");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, MN, MN), "rl6");
      step(mk(0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, MN, MN), "rl7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
